rgb_frame_writer: RTL and testbench

- Captures parallel RGB video (rgbClk domain) into a multi-buffered frame store in RAM.
- Generates true 2-D write addresses from x/y counters and crops to IMAGE_WIDTH x IMAGE_HEIGHT.
- Rotates between NB_BUFFERS frame buffers, never writes the buffer the display reader is using, and flags complete and short frames.
- Sits between the video input and the frame RAM write port; the driver-side reader consumes lastBuffer.

---
 rtl/rgb_pkg.sv | 32 +++
 rtl/rgb_sync_edge.sv | 37 +++
 rtl/rgb_frame_writer.sv | 170 +++++++++++++++++
 tb/tb_rgb_frame_writer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB frame capture path: capture state,
// pixel packing, frame-buffer rotation and frame size arithmetic.
package rgb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  function automatic longint unsigned frame_words(input int unsigned w,
                                                  input int unsigned h);
    return longint'(w) * longint'(h);
  endfunction

  // Result is right-aligned; the caller keeps the low out_w bits.
  function automatic logic [23:0] pack_pixel(input logic [23:0] rgb,
                                             input int unsigned out_w);
    if (out_w == 16) return {8'h00, rgb[23:19], rgb[15:10], rgb[7:3]};
    return rgb;
  endfunction

  // First buffer after wb (cyclically) that the reader is not using; wb itself if none.
  function automatic int unsigned next_buffer(input int unsigned wb,
                                              input int unsigned rb,
                                              input int unsigned nb);
    for (int unsigned k = 1; k < nb; k++) begin
      if ((wb + k) % nb != rb) return (wb + k) % nb;
    end
    return wb;
  endfunction

endpackage

// File: rtl/rgb_sync_edge.sv
// Registers hsync/vsync and reports rising/falling edges against the
// registered copy; shared with the display-side timing logic.
module rgb_sync_edge (
  input  logic rgbClk,
  input  logic nrst,
  input  logic hsync,
  input  logic vsync,
  output logic hsync_rise,
  output logic hsync_fall,
  output logic vsync_rise,
  output logic vsync_fall
);

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;

  always_comb begin
    hsync_d = hsync;
    vsync_d = vsync;
  end

  always_ff @(posedge rgbClk) begin
    if (!nrst) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign hsync_rise = hsync & ~hsync_q;
  assign hsync_fall = ~hsync & hsync_q;
  assign vsync_rise = vsync & ~vsync_q;
  assign vsync_fall = ~vsync & vsync_q;

endmodule

// File: rtl/rgb_frame_writer.sv
// Captures parallel RGB video into a rotating set of frame buffers with 2-D
// addressing, cropping, and complete/short frame reporting.
module rgb_frame_writer
  import rgb_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 32,
  parameter int RAM_DATA_WIDTH = 16,
  parameter int IMAGE_WIDTH    = 80,
  parameter int IMAGE_HEIGHT   = 48,
  parameter int NB_BUFFERS     = 2,
  parameter logic [RAM_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  localparam int BUF_W = (NB_BUFFERS > 2) ? $clog2(NB_BUFFERS) : 1
) (
  input  logic                      rgbClk,
  input  logic                      nrst,
  input  logic [23:0]               rgb,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic [BUF_W-1:0]          readBuffer,
  output logic [RAM_ADDR_WIDTH-1:0] ramAddr,
  output logic [RAM_DATA_WIDTH-1:0] ramData,
  output logic                      writeEnable,
  output logic                      frameDone,
  output logic                      frameError,
  output logic [BUF_W-1:0]          lastBuffer
);

  localparam int X_W = $clog2(IMAGE_WIDTH + 1);
  localparam int Y_W = $clog2(IMAGE_HEIGHT + 1);
  localparam logic [X_W-1:0] X_MAX = X_W'(IMAGE_WIDTH);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMAGE_HEIGHT);
  localparam logic [RAM_ADDR_WIDTH-1:0] LINE_WORDS  = RAM_ADDR_WIDTH'(IMAGE_WIDTH);
  localparam logic [RAM_ADDR_WIDTH-1:0] FRAME_WORDS =
    RAM_ADDR_WIDTH'(frame_words(IMAGE_WIDTH, IMAGE_HEIGHT));

  if (!(RAM_DATA_WIDTH == 16 || RAM_DATA_WIDTH == 24)) begin : g_bad_data_width
    $error("rgb_frame_writer: RAM_DATA_WIDTH must be 16 or 24");
  end
  if (NB_BUFFERS < 2) begin : g_bad_nb_buffers
    $error("rgb_frame_writer: NB_BUFFERS must be at least 2");
  end

  logic hsync_rise, hsync_fall_unused, vsync_rise, vsync_fall;

  rgb_sync_edge u_sync_edge (
    .rgbClk     (rgbClk),
    .nrst       (nrst),
    .hsync      (hsync),
    .vsync      (vsync),
    .hsync_rise (hsync_rise),
    .hsync_fall (hsync_fall_unused),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall)
  );

  state_t                    state_q, state_d;
  logic [X_W-1:0]            x_q, x_d;
  logic [Y_W-1:0]            y_q, y_d;
  logic [BUF_W-1:0]          wbuf_q, wbuf_d;
  logic [BUF_W-1:0]          last_buf_q, last_buf_d;
  logic [RAM_ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [RAM_DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                      we_q, we_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic                      active;
  logic                      line_open;
  logic [Y_W-1:0]            y_closed;
  logic [BUF_W-1:0]          nxt_buf;

  assign active    = ~hsync & ~vsync;
  assign line_open = (x_q != '0);
  // Line count as it stands once any open line is closed.
  assign y_closed  = (line_open && y_q != Y_MAX) ? y_q + Y_W'(1) : y_q;
  assign nxt_buf   = BUF_W'(next_buffer(32'(wbuf_q), 32'(readBuffer), NB_BUFFERS));

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    wbuf_d     = wbuf_q;
    last_buf_d = last_buf_q;
    row_base_d = row_base_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (vsync_fall) begin
          wbuf_d     = nxt_buf;
          x_d        = '0;
          y_d        = '0;
          row_base_d = BASE_ADDR + FRAME_WORDS * RAM_ADDR_WIDTH'(nxt_buf);
          state_d    = CAPTURE;
        end
      end
      CAPTURE: begin
        if (active) begin
          if (x_q < X_MAX && y_q < Y_MAX) begin
            we_d       = 1'b1;
            ram_addr_d = row_base_q + RAM_ADDR_WIDTH'(x_q);
            ram_data_d = RAM_DATA_WIDTH'(pack_pixel(rgb, RAM_DATA_WIDTH));
          end
          if (x_q != X_MAX) x_d = x_q + X_W'(1);
        end
        // A vsync rise also closes a line whose hsync rises in the same cycle.
        if (vsync_rise) begin
          if (y_closed == Y_MAX) begin
            done_d     = 1'b1;
            last_buf_d = wbuf_q;
          end else begin
            err_d      = 1'b1;
          end
          x_d     = '0;
          y_d     = y_closed;
          state_d = IDLE;
        end else if (hsync_rise && line_open) begin
          y_d = y_closed;
          if (y_q != Y_MAX) row_base_d = row_base_q + LINE_WORDS;
          x_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rgbClk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      wbuf_q     <= '0;
      last_buf_q <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      wbuf_q     <= wbuf_d;
      last_buf_q <= last_buf_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      we_q       <= we_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Row base is reloaded at every frame start before it is used.
  always_ff @(posedge rgbClk) begin
    row_base_q <= row_base_d;
  end

  assign ramAddr     = ram_addr_q;
  assign ramData     = ram_data_q;
  assign writeEnable = we_q;
  assign frameDone   = done_q;
  assign frameError  = err_q;
  assign lastBuffer  = last_buf_q;

endmodule

// File: tb/tb_rgb_frame_writer.sv
// Directed bench for rgb_frame_writer: 4x2 image, two buffers at 0x100, RGB565.
module tb_rgb_frame_writer;

  localparam logic [23:0] C0 = 24'hFF8040;
  localparam logic [23:0] C1 = 24'h0812F8;
  localparam logic [15:0] P0 = 16'hFC08;
  localparam logic [15:0] P1 = 16'h089F;

  logic        rgbClk = 1'b0;
  logic        nrst = 1'b0;
  logic [23:0] rgb = '0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [0:0]  readBuffer = '0;
  logic [31:0] ramAddr;
  logic [15:0] ramData;
  logic        writeEnable;
  logic        frameDone;
  logic        frameError;
  logic [0:0]  lastBuffer;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [31:0] wq[$];
  logic [15:0] dq[$];

  always #5 rgbClk = ~rgbClk;

  rgb_frame_writer #(
    .RAM_ADDR_WIDTH (32),
    .RAM_DATA_WIDTH (16),
    .IMAGE_WIDTH    (4),
    .IMAGE_HEIGHT   (2),
    .NB_BUFFERS     (2),
    .BASE_ADDR      (32'h100)
  ) dut (
    .rgbClk      (rgbClk),
    .nrst        (nrst),
    .rgb         (rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .readBuffer  (readBuffer),
    .ramAddr     (ramAddr),
    .ramData     (ramData),
    .writeEnable (writeEnable),
    .frameDone   (frameDone),
    .frameError  (frameError),
    .lastBuffer  (lastBuffer)
  );

  always @(negedge rgbClk) begin
    if (writeEnable) begin
      wq.push_back(ramAddr);
      dq.push_back(ramData);
    end
    if (frameDone)  done_cnt++;
    if (frameError) err_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic drive(input logic hs, input logic vs, input logic [23:0] px);
    hsync = hs;
    vsync = vs;
    rgb   = px;
    @(posedge rgbClk);
    #1;
  endtask

  task automatic clear_log();
    wq.delete();
    dq.delete();
  endtask

  // Pixels alternate C0/C1 by x position.
  task automatic run_frame(input int nlines, input int first_npx, input int npx,
                           input bit close_with_vsync);
    drive(1'b1, 1'b1, '0);
    drive(1'b1, 1'b1, '0);
    drive(1'b1, 1'b0, '0);
    for (int l = 0; l < nlines; l++) begin
      int n;
      n = (l == 0) ? first_npx : npx;
      for (int p = 0; p < n; p++) drive(1'b0, 1'b0, p[0] ? C1 : C0);
      if (!(close_with_vsync && l == nlines - 1)) begin
        drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
      end
    end
    drive(1'b1, 1'b1, '0);
    drive(1'b1, 1'b1, '0);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    drive(1'b1, 1'b1, C0);
    drive(1'b0, 1'b0, C0);
    drive(1'b1, 1'b1, C0);
    checks++; if (ramAddr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", ramAddr); end
    checks++; if (ramData !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0", ramData); end
    checks++; if (writeEnable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", writeEnable); end
    checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frameDone); end
    checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", frameError); end
    checks++; if (lastBuffer !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", lastBuffer); end
  endtask

  task automatic test_pre_vsync();
    clear_log();
    done_cnt = 0;
    err_cnt  = 0;
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, C0);
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, C1);
    drive(1'b0, 1'b0, C1);
    drive(1'b0, 1'b1, '0);
    drive(1'b1, 1'b1, '0);
    checks++; if (wq.size() !== 0) begin errors++; $display("FAIL pre_vsync_writes: got %0d want 0", wq.size()); end
    checks++; if (done_cnt !== 0 || err_cnt !== 0)
      begin errors++; $display("FAIL pre_vsync_pulses: done=%0d err=%0d want 0 0", done_cnt, err_cnt); end
  endtask

  task automatic test_full_frame();
    int d0;
    d0 = done_cnt;
    readBuffer = 1'b0;
    drive(1'b1, 1'b1, '0);
    drive(1'b1, 1'b0, '0);
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 4; p++) begin
        drive(1'b0, 1'b0, C0);
        checks++; if (writeEnable !== 1'b1 || ramAddr !== 32'h108 + 4*l + p || ramData !== P0) begin
          errors++;
          $display("FAIL full_pixel l%0d p%0d: we=%b addr=%h data=%h want 1 %h %h",
                   l, p, writeEnable, ramAddr, ramData, 32'h108 + 4*l + p, P0);
        end
      end
      drive(1'b1, 1'b0, '0);
      checks++; if (writeEnable !== 1'b0 || ramAddr !== 32'h10B + 4*l) begin
        errors++;
        $display("FAIL full_hold l%0d: we=%b addr=%h want 0 %h", l, writeEnable, ramAddr, 32'h10B + 4*l);
      end
    end
    drive(1'b1, 1'b1, '0);
    checks++; if (frameDone !== 1'b1 || frameError !== 1'b0)
      begin errors++; $display("FAIL full_done: done=%b err=%b want 1 0", frameDone, frameError); end
    checks++; if (lastBuffer !== 1'b1) begin errors++; $display("FAIL full_last: got %b want 1", lastBuffer); end
    drive(1'b1, 1'b1, '0);
    checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL full_done_pulse: got %b want 0", frameDone); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    readBuffer = 1'b0;
    drive(1'b1, 1'b1, '0);
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, C0);
    drive(1'b0, 1'b0, C1);
    checks++; if (writeEnable !== 1'b1 || ramAddr !== 32'h109)
      begin errors++; $display("FAIL mid_prewrite: we=%b addr=%h want 1 109", writeEnable, ramAddr); end
    nrst = 1'b0;
    drive(1'b0, 1'b0, C0);
    nrst = 1'b1;
    checks++; if (ramAddr !== 32'h0 || ramData !== 16'h0 || writeEnable !== 1'b0)
      begin errors++; $display("FAIL mid_reset_data: addr=%h data=%h we=%b want 0 0 0", ramAddr, ramData, writeEnable); end
    checks++; if (frameDone !== 1'b0 || frameError !== 1'b0 || lastBuffer !== 1'b0)
      begin errors++; $display("FAIL mid_reset_ctrl: done=%b err=%b last=%b want 0 0 0", frameDone, frameError, lastBuffer); end
    clear_log();
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, C0);
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, C0);
    drive(1'b1, 1'b1, '0);
    drive(1'b1, 1'b1, '0);
    checks++; if (wq.size() !== 0) begin errors++; $display("FAIL mid_no_write: got %0d writes want 0", wq.size()); end
    checks++; if (done_cnt !== d0 || err_cnt !== e0)
      begin errors++; $display("FAIL mid_no_pulse: done=%0d err=%0d want %0d %0d", done_cnt, err_cnt, d0, e0); end
    run_frame(2, 4, 4, 1'b0);
    checks++; if (wq.size() !== 8) begin errors++; $display("FAIL mid_restart_count: got %0d want 8", wq.size()); end
    for (int i = 0; i < wq.size() && i < 8; i++) begin
      checks++; if (wq[i] !== 32'h108 + i || dq[i] !== ((i % 2 == 0) ? P0 : P1))
        begin errors++; $display("FAIL mid_restart_w%0d: addr=%h data=%h want %h", i, wq[i], dq[i], 32'h108 + i); end
    end
    checks++; if (lastBuffer !== 1'b1) begin errors++; $display("FAIL mid_restart_last: got %b want 1", lastBuffer); end
  endtask

  task automatic test_crop();
    int d0, e0;
    clear_log();
    d0 = done_cnt;
    e0 = err_cnt;
    readBuffer = 1'b1;
    run_frame(3, 6, 4, 1'b0);
    checks++; if (wq.size() !== 8) begin errors++; $display("FAIL crop_count: got %0d want 8", wq.size()); end
    for (int i = 0; i < wq.size() && i < 8; i++) begin
      checks++; if (wq[i] !== 32'h100 + i || dq[i] !== ((i % 2 == 0) ? P0 : P1))
        begin errors++; $display("FAIL crop_w%0d: addr=%h data=%h want %h", i, wq[i], dq[i], 32'h100 + i); end
    end
    checks++; if (done_cnt - d0 !== 1 || err_cnt !== e0)
      begin errors++; $display("FAIL crop_pulses: done=+%0d err=+%0d want +1 +0", done_cnt - d0, err_cnt - e0); end
    checks++; if (lastBuffer !== 1'b0) begin errors++; $display("FAIL crop_last: got %b want 0", lastBuffer); end
  endtask

  task automatic test_short_frame();
    int d0, e0;
    clear_log();
    d0 = done_cnt;
    e0 = err_cnt;
    readBuffer = 1'b0;
    run_frame(1, 4, 4, 1'b0);
    checks++; if (wq.size() !== 4) begin errors++; $display("FAIL short_count: got %0d want 4", wq.size()); end
    for (int i = 0; i < wq.size() && i < 4; i++) begin
      checks++; if (wq[i] !== 32'h108 + i)
        begin errors++; $display("FAIL short_w%0d: addr=%h want %h", i, wq[i], 32'h108 + i); end
    end
    checks++; if (err_cnt - e0 !== 1 || done_cnt !== d0)
      begin errors++; $display("FAIL short_pulses: err=+%0d done=+%0d want +1 +0", err_cnt - e0, done_cnt - d0); end
    checks++; if (lastBuffer !== 1'b0) begin errors++; $display("FAIL short_last: got %b want 0", lastBuffer); end
  endtask

  task automatic test_simul_edges();
    int d0, e0;
    clear_log();
    d0 = done_cnt;
    e0 = err_cnt;
    readBuffer = 1'b0;
    run_frame(2, 4, 4, 1'b1);
    checks++; if (wq.size() !== 8) begin errors++; $display("FAIL simul_count: got %0d want 8", wq.size()); end
    for (int i = 0; i < wq.size() && i < 8; i++) begin
      checks++; if (wq[i] !== 32'h108 + i)
        begin errors++; $display("FAIL simul_w%0d: addr=%h want %h", i, wq[i], 32'h108 + i); end
    end
    checks++; if (done_cnt - d0 !== 1 || err_cnt !== e0)
      begin errors++; $display("FAIL simul_pulses: done=+%0d err=+%0d want +1 +0", done_cnt - d0, err_cnt - e0); end
    checks++; if (lastBuffer !== 1'b1) begin errors++; $display("FAIL simul_last: got %b want 1", lastBuffer); end
  endtask

  task automatic test_back_to_back_reuse();
    readBuffer = 1'b1;
    for (int f = 0; f < 3; f++) begin
      int bad;
      clear_log();
      run_frame(2, 4, 4, 1'b0);
      bad = 0;
      for (int i = 0; i < wq.size(); i++) if (wq[i] !== 32'h100 + i) bad++;
      checks++; if (wq.size() !== 8 || bad !== 0)
        begin errors++; $display("FAIL reuse_f%0d: writes=%0d wrong_addr=%0d want 8 0", f, wq.size(), bad); end
      checks++; if (lastBuffer !== 1'b0) begin errors++; $display("FAIL reuse_last_f%0d: got %b want 0", f, lastBuffer); end
    end
  endtask

  initial begin
    test_reset();
    test_pre_vsync();
    test_full_frame();
    test_reset_mid();
    test_crop();
    test_short_frame();
    test_simul_edges();
    test_back_to_back_reuse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
